// File: rtl/hpdcache_mem_resp_pkg.sv
// hpdcache_mem_resp_pkg
// Shared definitions for the memory responder: read/write FSM state encodings
// and the address decode that turns a byte address into a line index plus an
// out-of-range flag.
package hpdcache_mem_resp_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_BEAT
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef struct packed {
        logic [31:0] idx;
        logic        outOfRange;
    } line_loc_t;

    // Drops the byte offset inside a line, keeps idxBits of line number, and
    // flags any non-zero line-number bit above those as out of range.
    function automatic line_loc_t lineLocate(input logic [63:0] addr,
                                             input int unsigned offBits,
                                             input int unsigned idxBits);
        line_loc_t   loc;
        logic [63:0] lineNum;
        lineNum        = addr >> offBits;
        loc.idx        = 32'(lineNum & ((64'd1 << idxBits) - 64'd1));
        loc.outOfRange = |(lineNum >> idxBits);
        return loc;
    endfunction

endpackage

// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg
// Minimal HPDcache configuration and memory-interface definitions needed by
// the memory responder: the build configuration record, the memory command
// encodings and the default request/response payload structures.
package hpdcache_pkg;

    typedef struct packed {
        int unsigned memAddrWidth;
        int unsigned memIdWidth;
        int unsigned memDataWidth;
    } hpdcache_cfg_t;

    localparam hpdcache_cfg_t hpdcacheBuildConfig = '{
        memAddrWidth: 64,
        memIdWidth:   8,
        memDataWidth: 512
    };

    localparam int unsigned MemAddrWidth = hpdcacheBuildConfig.memAddrWidth;
    localparam int unsigned MemIdWidth   = hpdcacheBuildConfig.memIdWidth;
    localparam int unsigned MemDataWidth = hpdcacheBuildConfig.memDataWidth;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'b00,
        HPDCACHE_MEM_WRITE  = 2'b01,
        HPDCACHE_MEM_ATOMIC = 2'b10
    } hpdcache_mem_command_e;

    typedef struct packed {
        logic [MemAddrWidth-1:0] mem_req_addr;
        logic [7:0]              mem_req_len;
        logic [2:0]              mem_req_size;
        logic [MemIdWidth-1:0]   mem_req_id;
        hpdcache_mem_command_e   mem_req_command;
        logic                    mem_req_atomic;
        logic                    mem_req_cacheable;
    } mem_req_default_t;

    typedef struct packed {
        logic [MemDataWidth-1:0]   mem_req_w_data;
        logic [MemDataWidth/8-1:0] mem_req_w_be;
        logic                      mem_req_w_last;
    } mem_req_w_default_t;

    typedef struct packed {
        logic                    mem_resp_r_error;
        logic [MemIdWidth-1:0]   mem_resp_r_id;
        logic [MemDataWidth-1:0] mem_resp_r_data;
        logic                    mem_resp_r_last;
    } mem_resp_r_default_t;

    typedef struct packed {
        logic                  mem_resp_w_is_atomic;
        logic                  mem_resp_w_error;
        logic [MemIdWidth-1:0] mem_resp_w_id;
    } mem_resp_w_default_t;

endpackage

// File: rtl/hpdcache_mem_resp_array.sv
// hpdcache_mem_resp_array
// Flop-based line store: MemDepth lines of memDataWidth bits, one byte-enabled
// synchronous write port and one asynchronous read port. A read of the line
// being written in the same cycle returns the old contents. Not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable for this cycle
//   waddr_i  line written
//   wdata_i  write data
//   wbe_i    per-byte write enable
//   raddr_i  line read
//   rdata_o  read data (combinational)
module hpdcache_mem_resp_array #(
    parameter int unsigned MemDepth     = 1024,
    parameter int unsigned memDataWidth = 512,
    localparam int unsigned IdxW        = $clog2(MemDepth),
    localparam int unsigned BeW         = memDataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IdxW-1:0]         waddr_i,
    input  logic [memDataWidth-1:0] wdata_i,
    input  logic [BeW-1:0]          wbe_i,
    input  logic [IdxW-1:0]         raddr_i,
    output logic [memDataWidth-1:0] rdata_o
);

    logic [memDataWidth-1:0] mem_q [MemDepth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(BeW); b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hpdcache_mem_responder.sv
// hpdcache_mem_responder
// Memory-side endpoint for the HPDcache memory interface. Independent read
// and write FSMs share one line array. Reads return len+1 beats after a fixed
// latency; writes consume beats until last and then send one response.
// Illegal requests (out of range, wrong command, atomics) are answered with
// error=1, zero read data and no memory update.
// Ports:
//   clk_i / rst_ni                 clock, asynchronous active-low reset
//   mem_req_read_*                 read request channel (in)
//   mem_resp_read_*                read response beats (out)
//   mem_req_write_*                write request channel (in)
//   mem_req_write_data_*           write data beats (in)
//   mem_resp_write_*               write response (out)
module hpdcache_mem_responder
    import hpdcache_mem_resp_pkg::*;
#(
    parameter hpdcache_pkg::hpdcache_cfg_t HPDcacheCfg = hpdcache_pkg::hpdcacheBuildConfig,
    parameter int unsigned MemDepth    = 1024,
    parameter int unsigned ReadLatency = 2,
    parameter type hpdcache_mem_req_t    = hpdcache_pkg::mem_req_default_t,
    parameter type hpdcache_mem_req_w_t  = hpdcache_pkg::mem_req_w_default_t,
    parameter type hpdcache_mem_resp_r_t = hpdcache_pkg::mem_resp_r_default_t,
    parameter type hpdcache_mem_resp_w_t = hpdcache_pkg::mem_resp_w_default_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    output logic                 mem_req_read_ready_o,
    input  logic                 mem_req_read_valid_i,
    input  hpdcache_mem_req_t    mem_req_read_i,

    input  logic                 mem_resp_read_ready_i,
    output logic                 mem_resp_read_valid_o,
    output hpdcache_mem_resp_r_t mem_resp_read_o,

    output logic                 mem_req_write_ready_o,
    input  logic                 mem_req_write_valid_i,
    input  hpdcache_mem_req_t    mem_req_write_i,

    output logic                 mem_req_write_data_ready_o,
    input  logic                 mem_req_write_data_valid_i,
    input  hpdcache_mem_req_w_t  mem_req_write_data_i,

    input  logic                 mem_resp_write_ready_i,
    output logic                 mem_resp_write_valid_o,
    output hpdcache_mem_resp_w_t mem_resp_write_o
);

    localparam int unsigned AddrW = HPDcacheCfg.memAddrWidth;
    localparam int unsigned IdW   = HPDcacheCfg.memIdWidth;
    localparam int unsigned DataW = HPDcacheCfg.memDataWidth;
    localparam int unsigned OffW  = $clog2(DataW / 8);
    localparam int unsigned IdxW  = $clog2(MemDepth);
    // WAIT is entered with this many extra cycles still to burn.
    localparam logic [3:0] WaitInit = (ReadLatency > 1) ? 4'(ReadLatency - 2) : 4'd0;

    rd_state_e         rdState_q, rdState_d;
    logic [IdW-1:0]    rdId_q, rdId_d;
    logic [IdxW-1:0]   rdIdx_q, rdIdx_d;
    logic [8:0]        rdRemain_q, rdRemain_d;
    logic              rdErr_q, rdErr_d;
    logic [3:0]        rdLat_q, rdLat_d;

    wr_state_e         wrState_q, wrState_d;
    logic [IdW-1:0]    wrId_q, wrId_d;
    logic [IdxW-1:0]   wrIdx_q, wrIdx_d;
    logic              wrErr_q, wrErr_d;

    logic [AddrW-1:0]  rdAddr, wrAddr;
    line_loc_t         rdLoc, wrLoc;
    logic              arrWe;
    logic [DataW-1:0]  arrRdata;

    assign rdAddr = mem_req_read_i.mem_req_addr;
    assign wrAddr = mem_req_write_i.mem_req_addr;
    assign rdLoc  = lineLocate(64'(rdAddr), OffW, IdxW);
    assign wrLoc  = lineLocate(64'(wrAddr), OffW, IdxW);

    hpdcache_mem_resp_array #(
        .MemDepth    (MemDepth),
        .memDataWidth(DataW)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arrWe),
        .waddr_i(wrIdx_q),
        .wdata_i(mem_req_write_data_i.mem_req_w_data),
        .wbe_i  (mem_req_write_data_i.mem_req_w_be),
        .raddr_i(rdIdx_q),
        .rdata_o(arrRdata)
    );

    // Read FSM: capture request, wait out the latency, stream beats with a
    // wrapping line index. Payload is zero whenever no beat is presented.
    always_comb begin
        rdState_d             = rdState_q;
        rdId_d                = rdId_q;
        rdIdx_d               = rdIdx_q;
        rdRemain_d            = rdRemain_q;
        rdErr_d               = rdErr_q;
        rdLat_d               = rdLat_q;
        mem_req_read_ready_o  = 1'b0;
        mem_resp_read_valid_o = 1'b0;
        mem_resp_read_o       = '0;
        case (rdState_q)
            RD_IDLE: begin
                mem_req_read_ready_o = 1'b1;
                if (mem_req_read_valid_i) begin
                    rdId_d     = mem_req_read_i.mem_req_id;
                    rdIdx_d    = rdLoc.idx[IdxW-1:0];
                    rdRemain_d = {1'b0, mem_req_read_i.mem_req_len} + 9'd1;
                    rdErr_d    = rdLoc.outOfRange |
                                 (mem_req_read_i.mem_req_command != hpdcache_pkg::HPDCACHE_MEM_READ);
                    rdLat_d    = WaitInit;
                    rdState_d  = (ReadLatency > 1) ? RD_WAIT : RD_BEAT;
                end
            end
            RD_WAIT: begin
                if (rdLat_q == 4'd0) begin
                    rdState_d = RD_BEAT;
                end else begin
                    rdLat_d = rdLat_q - 4'd1;
                end
            end
            RD_BEAT: begin
                mem_resp_read_valid_o           = 1'b1;
                mem_resp_read_o.mem_resp_r_error = rdErr_q;
                mem_resp_read_o.mem_resp_r_id    = rdId_q;
                mem_resp_read_o.mem_resp_r_data  = rdErr_q ? '0 : arrRdata;
                mem_resp_read_o.mem_resp_r_last  = (rdRemain_q == 9'd1);
                if (mem_resp_read_ready_i) begin
                    rdRemain_d = rdRemain_q - 9'd1;
                    rdIdx_d    = rdIdx_q + IdxW'(1);
                    if (rdRemain_q == 9'd1) begin
                        rdState_d = RD_IDLE;
                    end
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    // Write FSM: data is only accepted after its request, so early data simply
    // waits. Errored transactions drain their beats without touching memory.
    always_comb begin
        wrState_d                  = wrState_q;
        wrId_d                     = wrId_q;
        wrIdx_d                    = wrIdx_q;
        wrErr_d                    = wrErr_q;
        arrWe                      = 1'b0;
        mem_req_write_ready_o      = 1'b0;
        mem_req_write_data_ready_o = 1'b0;
        mem_resp_write_valid_o     = 1'b0;
        mem_resp_write_o           = '0;
        case (wrState_q)
            WR_IDLE: begin
                mem_req_write_ready_o = 1'b1;
                if (mem_req_write_valid_i) begin
                    wrId_d    = mem_req_write_i.mem_req_id;
                    wrIdx_d   = wrLoc.idx[IdxW-1:0];
                    wrErr_d   = wrLoc.outOfRange |
                                (mem_req_write_i.mem_req_command != hpdcache_pkg::HPDCACHE_MEM_WRITE) |
                                mem_req_write_i.mem_req_atomic;
                    wrState_d = WR_DATA;
                end
            end
            WR_DATA: begin
                mem_req_write_data_ready_o = 1'b1;
                if (mem_req_write_data_valid_i) begin
                    arrWe   = ~wrErr_q;
                    wrIdx_d = wrIdx_q + IdxW'(1);
                    if (mem_req_write_data_i.mem_req_w_last) begin
                        wrState_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                mem_resp_write_valid_o                = 1'b1;
                mem_resp_write_o.mem_resp_w_is_atomic = 1'b0;
                mem_resp_write_o.mem_resp_w_error     = wrErr_q;
                mem_resp_write_o.mem_resp_w_id        = wrId_q;
                if (mem_resp_write_ready_i) begin
                    wrState_d = WR_IDLE;
                end
            end
            default: wrState_d = WR_IDLE;
        endcase
    end

    // State registers for both FSMs; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdState_q  <= RD_IDLE;
            rdId_q     <= '0;
            rdIdx_q    <= '0;
            rdRemain_q <= '0;
            rdErr_q    <= 1'b0;
            rdLat_q    <= '0;
            wrState_q  <= WR_IDLE;
            wrId_q     <= '0;
            wrIdx_q    <= '0;
            wrErr_q    <= 1'b0;
        end else begin
            rdState_q  <= rdState_d;
            rdId_q     <= rdId_d;
            rdIdx_q    <= rdIdx_d;
            rdRemain_q <= rdRemain_d;
            rdErr_q    <= rdErr_d;
            rdLat_q    <= rdLat_d;
            wrState_q  <= wrState_d;
            wrId_q     <= wrId_d;
            wrIdx_q    <= wrIdx_d;
            wrErr_q    <= wrErr_d;
        end
    end

    // Request fields this memory has no use for (size, cacheability, write
    // length, read atomic flag, index bits above the array depth).
    logic unusedBits;
    assign unusedBits = ^{mem_req_read_i.mem_req_size, mem_req_read_i.mem_req_cacheable,
                          mem_req_read_i.mem_req_atomic, mem_req_write_i.mem_req_len,
                          mem_req_write_i.mem_req_size, mem_req_write_i.mem_req_cacheable,
                          rdLoc.idx[31:IdxW], wrLoc.idx[31:IdxW]};

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// tb_hpdcache_mem_responder
// Self-checking bench: a table of single-beat read/write vectors plus
// hand-written sequences for wrapping bursts with random stalls, early write
// data and reset in the middle of a burst. Expected responses are queued when
// requests are issued and checked as the DUT hands them back.
module tb_hpdcache_mem_responder;
    import hpdcache_pkg::*;

    localparam int RdLat = 2;
    localparam logic [63:0] BeAll = '1;

    logic clk = 1'b0;
    logic rstN;

    logic                rdReqReady, rdReqValid;
    mem_req_default_t    rdReq;
    logic                rdRespReady, rdRespValid;
    mem_resp_r_default_t rdResp;
    logic                wrReqReady, wrReqValid;
    mem_req_default_t    wrReq;
    logic                wrDataReady, wrDataValid;
    mem_req_w_default_t  wrData;
    logic                wrRespReady, wrRespValid;
    mem_resp_w_default_t wrResp;

    always #5 clk = ~clk;

    hpdcache_mem_responder #(
        .MemDepth   (1024),
        .ReadLatency(RdLat)
    ) dut (
        .clk_i                     (clk),
        .rst_ni                    (rstN),
        .mem_req_read_ready_o      (rdReqReady),
        .mem_req_read_valid_i      (rdReqValid),
        .mem_req_read_i            (rdReq),
        .mem_resp_read_ready_i     (rdRespReady),
        .mem_resp_read_valid_o     (rdRespValid),
        .mem_resp_read_o           (rdResp),
        .mem_req_write_ready_o     (wrReqReady),
        .mem_req_write_valid_i     (wrReqValid),
        .mem_req_write_i           (wrReq),
        .mem_req_write_data_ready_o(wrDataReady),
        .mem_req_write_data_valid_i(wrDataValid),
        .mem_req_write_data_i      (wrData),
        .mem_resp_write_ready_i    (wrRespReady),
        .mem_resp_write_valid_o    (wrRespValid),
        .mem_resp_write_o          (wrResp)
    );

    typedef struct {
        logic [511:0] data;
        logic [7:0]   id;
        logic         err;
        logic         last;
    } rd_exp_t;

    typedef struct {
        logic [7:0] id;
        logic       err;
    } wr_exp_t;

    typedef struct {
        logic                  isWrite;
        logic [63:0]           addr;
        logic [7:0]            id;
        hpdcache_mem_command_e cmd;
        logic                  atomic;
        logic [7:0]            fill;
        logic [63:0]           be;
        logic                  expErr;
        logic [511:0]          expData;
    } vec_t;

    rd_exp_t rdExpQ[$];
    wr_exp_t wrExpQ[$];
    vec_t    vecs[13];

    int vecCount  = 0;
    int missCount = 0;

    function automatic logic [511:0] fillLine(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [599:0] actual,
                               input logic [599:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        vecCount++;
        missCount++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Read response monitor: compares every transferred beat against the
    // queue and checks that a stalled beat stays unchanged.
    logic                holdActive = 1'b0;
    mem_resp_r_default_t heldBeat;
    always @(negedge clk) begin : rdMon
        rd_exp_t e;
        if (rstN && rdRespValid) begin
            if (holdActive) checkOutput("read-stall-hold", rdResp, heldBeat);
            if (rdRespReady) begin
                holdActive = 1'b0;
                if (rdExpQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL read-unexpected: got beat id %0h expected none", rdResp.mem_resp_r_id);
                end else begin
                    e = rdExpQ.pop_front();
                    checkOutput("read-data", rdResp.mem_resp_r_data, e.data);
                    checkOutput("read-id", rdResp.mem_resp_r_id, e.id);
                    checkOutput("read-error", rdResp.mem_resp_r_error, e.err);
                    checkOutput("read-last", rdResp.mem_resp_r_last, e.last);
                end
            end else begin
                holdActive = 1'b1;
                heldBeat   = rdResp;
            end
        end else begin
            holdActive = 1'b0;
        end
    end

    // Write response monitor.
    always @(negedge clk) begin : wrMon
        wr_exp_t e;
        if (rstN && wrRespValid && wrRespReady) begin
            if (wrExpQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL write-unexpected: got resp id %0h expected none", wrResp.mem_resp_w_id);
            end else begin
                e = wrExpQ.pop_front();
                checkOutput("write-id", wrResp.mem_resp_w_id, e.id);
                checkOutput("write-error", wrResp.mem_resp_w_error, e.err);
                checkOutput("write-is-atomic", wrResp.mem_resp_w_is_atomic, 1'b0);
            end
        end
    end

    task automatic readTxn(input logic [63:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input hpdcache_mem_command_e cmd);
        int n;
        int lat;
        @(posedge clk); #1;
        rdReq                   = '0;
        rdReq.mem_req_addr      = addr;
        rdReq.mem_req_len       = len;
        rdReq.mem_req_size      = 3'd6;
        rdReq.mem_req_id        = id;
        rdReq.mem_req_command   = cmd;
        rdReq.mem_req_cacheable = 1'b1;
        rdReqValid              = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdReqReady) reportTimeout("read-req-accept");
        @(posedge clk); #1;
        rdReqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdRespValid && lat < 50);
        checkOutput("read-latency", lat, RdLat);
    endtask

    task automatic waitReadDone(input bit stall);
        int n = 0;
        while (rdExpQ.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            if (stall) rdRespReady = 1'($urandom_range(0, 1));
            n++;
        end
        rdRespReady = 1'b1;
        if (rdExpQ.size() != 0) begin
            reportTimeout("read-beats");
            rdExpQ.delete();
        end
    endtask

    task automatic writeTxn(input logic [63:0] addr, input logic [7:0] id,
                            input hpdcache_mem_command_e cmd, input logic atomic,
                            input logic [7:0] fill, input logic [63:0] be,
                            input int beats, input int dataLead);
        int n;
        @(posedge clk); #1;
        if (dataLead > 0) begin
            wrData.mem_req_w_data = fillLine(fill);
            wrData.mem_req_w_be   = be;
            wrData.mem_req_w_last = (beats == 1);
            wrDataValid           = 1'b1;
            for (int i = 0; i < dataLead; i++) begin
                @(negedge clk);
                checkOutput("wdata-ready-early", wrDataReady, 1'b0);
                @(posedge clk); #1;
            end
        end
        wrReq                   = '0;
        wrReq.mem_req_addr      = addr;
        wrReq.mem_req_size      = 3'd6;
        wrReq.mem_req_len       = 8'(beats - 1);
        wrReq.mem_req_id        = id;
        wrReq.mem_req_command   = cmd;
        wrReq.mem_req_atomic    = atomic;
        wrReq.mem_req_cacheable = 1'b1;
        wrReqValid              = 1'b1;
        n = 0;
        @(negedge clk);
        if (dataLead > 0) checkOutput("wdata-ready-idle", wrDataReady, 1'b0);
        while (!wrReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wrReqReady) reportTimeout("write-req-accept");
        @(posedge clk); #1;
        wrReqValid = 1'b0;
        for (int k = 0; k < beats; k++) begin
            wrData.mem_req_w_data = fillLine(fill + 8'(k));
            wrData.mem_req_w_be   = be;
            wrData.mem_req_w_last = (k == beats - 1);
            wrDataValid           = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wrDataReady && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!wrDataReady) reportTimeout("write-data-accept");
            @(posedge clk); #1;
        end
        wrDataValid = 1'b0;
        n = 0;
        while (wrExpQ.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (wrExpQ.size() != 0) begin
            reportTimeout("write-resp");
            wrExpQ.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) begin
            wrExpQ.push_back('{id: v.id, err: v.expErr});
            writeTxn(v.addr, v.id, v.cmd, v.atomic, v.fill, v.be, 1, 0);
        end else begin
            rdExpQ.push_back('{data: v.expData, id: v.id, err: v.expErr, last: 1'b1});
            readTxn(v.addr, 8'd0, v.id, v.cmd);
            waitReadDone(1'b0);
        end
    endtask

    // Global time limit so a stuck handshake still ends with a summary.
    initial begin
        #800000;
        missCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        logic [63:0]  oorAddr;
        logic [511:0] mixedLine;
        oorAddr   = (64'd1 << 60) | 64'h1000;
        mixedLine = {8{64'h11111111EEEEEEEE}};

        vecs[0]  = '{isWrite:1'b1, addr:64'h1000, id:8'h03, cmd:HPDCACHE_MEM_WRITE, atomic:1'b0, fill:8'hA5, be:BeAll, expErr:1'b0, expData:'0};
        vecs[1]  = '{isWrite:1'b0, addr:64'h1000, id:8'h05, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b0, expData:fillLine(8'hA5)};
        vecs[2]  = '{isWrite:1'b1, addr:64'h2000, id:8'h01, cmd:HPDCACHE_MEM_WRITE, atomic:1'b0, fill:8'h11, be:BeAll, expErr:1'b0, expData:'0};
        vecs[3]  = '{isWrite:1'b1, addr:64'h2000, id:8'h02, cmd:HPDCACHE_MEM_WRITE, atomic:1'b0, fill:8'hEE, be:64'h0F0F0F0F0F0F0F0F, expErr:1'b0, expData:'0};
        vecs[4]  = '{isWrite:1'b0, addr:64'h2010, id:8'h06, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b0, expData:mixedLine};
        vecs[5]  = '{isWrite:1'b1, addr:oorAddr,  id:8'h07, cmd:HPDCACHE_MEM_WRITE, atomic:1'b0, fill:8'h5A, be:BeAll, expErr:1'b1, expData:'0};
        vecs[6]  = '{isWrite:1'b0, addr:64'h1000, id:8'h08, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b0, expData:fillLine(8'hA5)};
        vecs[7]  = '{isWrite:1'b1, addr:64'h1000, id:8'h09, cmd:HPDCACHE_MEM_WRITE, atomic:1'b1, fill:8'h3C, be:BeAll, expErr:1'b1, expData:'0};
        vecs[8]  = '{isWrite:1'b0, addr:64'h1000, id:8'h0A, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b0, expData:fillLine(8'hA5)};
        vecs[9]  = '{isWrite:1'b0, addr:oorAddr,  id:8'h0B, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b1, expData:'0};
        vecs[10] = '{isWrite:1'b0, addr:64'h1000, id:8'h0C, cmd:HPDCACHE_MEM_WRITE, atomic:1'b0, fill:8'h00, be:'0, expErr:1'b1, expData:'0};
        vecs[11] = '{isWrite:1'b1, addr:64'h2000, id:8'h0D, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h77, be:BeAll, expErr:1'b1, expData:'0};
        vecs[12] = '{isWrite:1'b0, addr:64'h2000, id:8'h0E, cmd:HPDCACHE_MEM_READ,  atomic:1'b0, fill:8'h00, be:'0, expErr:1'b0, expData:mixedLine};

        rstN        = 1'b0;
        rdReqValid  = 1'b0;
        rdReq       = '0;
        rdRespReady = 1'b1;
        wrReqValid  = 1'b0;
        wrReq       = '0;
        wrDataValid = 1'b0;
        wrData      = '0;
        wrRespReady = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset-rd-req-ready", rdReqReady, 1'b1);
        checkOutput("reset-wr-req-ready", wrReqReady, 1'b1);
        checkOutput("reset-wr-data-ready", wrDataReady, 1'b0);
        checkOutput("reset-rd-resp-valid", rdRespValid, 1'b0);
        checkOutput("reset-wr-resp-valid", wrRespValid, 1'b0);
        checkOutput("reset-rd-resp-payload", rdResp, '0);
        checkOutput("reset-wr-resp-payload", wrResp, '0);
        @(posedge clk); #1;
        rstN = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end

        // Wrapping burst: fill lines 1023,0,1,2 with one burst write, then read
        // them back as one burst under random response stalls.
        wrExpQ.push_back('{id: 8'h20, err: 1'b0});
        writeTxn(64'hFFC0, 8'h20, HPDCACHE_MEM_WRITE, 1'b0, 8'h70, BeAll, 4, 0);
        for (int k = 0; k < 4; k++) begin
            rdExpQ.push_back('{data: fillLine(8'h70 + 8'(k)), id: 8'h21, err: 1'b0, last: (k == 3)});
        end
        readTxn(64'hFFC0, 8'd3, 8'h21, HPDCACHE_MEM_READ);
        waitReadDone(1'b1);

        // Write data raised three cycles before its request.
        wrExpQ.push_back('{id: 8'h30, err: 1'b0});
        writeTxn(64'hC000, 8'h30, HPDCACHE_MEM_WRITE, 1'b0, 8'hC3, BeAll, 1, 3);
        rdExpQ.push_back('{data: fillLine(8'hC3), id: 8'h31, err: 1'b0, last: 1'b1});
        readTxn(64'hC000, 8'd0, 8'h31, HPDCACHE_MEM_READ);
        waitReadDone(1'b0);

        // Reset while beat 2 of a 4-beat burst is being presented.
        for (int k = 0; k < 4; k++) begin
            rdExpQ.push_back('{data: fillLine(8'h70 + 8'(k)), id: 8'h40, err: 1'b0, last: (k == 3)});
        end
        rdRespReady = 1'b0;
        readTxn(64'hFFC0, 8'd3, 8'h40, HPDCACHE_MEM_READ);
        @(posedge clk); #1;
        rdRespReady = 1'b1;
        @(posedge clk); #1;
        rdRespReady = 1'b0;
        @(negedge clk);
        checkOutput("beat2-valid", rdRespValid, 1'b1);
        checkOutput("beat2-data", rdResp.mem_resp_r_data, fillLine(8'h71));
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("midreset-rd-valid", rdRespValid, 1'b0);
        checkOutput("midreset-wr-valid", wrRespValid, 1'b0);
        checkOutput("midreset-rd-req-ready", rdReqReady, 1'b1);
        checkOutput("midreset-wr-req-ready", wrReqReady, 1'b1);
        rdExpQ.delete();
        rdRespReady = 1'b1;
        @(posedge clk); #1;
        rstN = 1'b1;
        rdExpQ.push_back('{data: fillLine(8'hA5), id: 8'h41, err: 1'b0, last: 1'b1});
        readTxn(64'h1000, 8'd0, 8'h41, HPDCACHE_MEM_READ);
        waitReadDone(1'b0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
